// File: rtl/spiflash_pkg.sv
// Shared types and constants for the single-bit SPI flash responder.
package spiflash_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    ID,
    IGNORE
  } state_e;

  localparam logic [7:0]  CMD_READ  = 8'h03;
  localparam logic [7:0]  CMD_RDID  = 8'h9F;
  localparam int unsigned BIT_CNT_W = 5;
  localparam int unsigned ADDR_SH_W = 24;

  // Selects one of the three JEDEC ID bytes, MSB byte first.
  function automatic logic [7:0] id_byte(input logic [23:0] id, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = id[23:16];
      2'd1:    b = id[15:8];
      2'd2:    b = id[7:0];
      default: b = id[23:16];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronisers for the SPI pins plus SCK edge pulses, all on the system clock.
module spi_pin_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic csb_i,
  input  logic sck_i,
  input  logic io0_i,
  output logic csb_o,
  output logic io0_o,
  output logic sck_rise_c,
  output logic sck_fall_c
);

  logic csb_meta_q, csb_q;
  logic sck_meta_q, sck_q, sck_dly_q;
  logic io0_meta_q, io0_q;

  // CSB resets high so a low CSB at reset release is treated as a fresh select.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      csb_meta_q <= 1'b1;
      csb_q      <= 1'b1;
      sck_meta_q <= 1'b0;
      sck_q      <= 1'b0;
      sck_dly_q  <= 1'b0;
      io0_meta_q <= 1'b0;
      io0_q      <= 1'b0;
    end else begin
      csb_meta_q <= csb_i;
      csb_q      <= csb_meta_q;
      sck_meta_q <= sck_i;
      sck_q      <= sck_meta_q;
      sck_dly_q  <= sck_q;
      io0_meta_q <= io0_i;
      io0_q      <= io0_meta_q;
    end
  end

  assign csb_o      = csb_q;
  assign io0_o      = io0_q;
  assign sck_rise_c = sck_q & ~sck_dly_q;
  assign sck_fall_c = ~sck_q & sck_dly_q;

endmodule

// File: rtl/spiflash_responder.sv
// SPI flash responder (mode 0, single bit): answers READ from a byte memory port and JEDEC ID.
module spiflash_responder
  import spiflash_pkg::*;
#(
  parameter int unsigned ADDR_W   = 10,
  parameter logic [23:0] JEDEC_ID = 24'hEF4018
) (
  input  logic              wb_clk_i,
  input  logic              wb_rstn_i,
  input  logic              flash_csb,
  input  logic              flash_clk,
  input  logic              flash_io0_di,
  output logic              flash_io1_do,
  output logic              flash_io1_oeb,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [7:0]        mem_rdata_i,
  output logic              busy_o,
  output logic [7:0]        cmd_o
);

  logic csb_s, io0_s, sck_rise, sck_fall;

  spi_pin_sync u_sync (
    .clk_i      (wb_clk_i),
    .rst_ni     (wb_rstn_i),
    .csb_i      (flash_csb),
    .sck_i      (flash_clk),
    .io0_i      (flash_io0_di),
    .csb_o      (csb_s),
    .io0_o      (io0_s),
    .sck_rise_c (sck_rise),
    .sck_fall_c (sck_fall)
  );

  state_e               state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  // The final address bit comes straight from io0, so only 23 bits are stored.
  logic [ADDR_SH_W-2:0] addr_sh_q, addr_sh_d;
  logic [7:0]           tx_sh_q, tx_sh_d;
  logic [1:0]           id_idx_q, id_idx_d;
  logic [7:0]           cmd_q, cmd_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 rd_q, rd_d;
  logic                 pend_q, pend_d;
  logic                 do_q, do_d;
  logic                 oeb_q, oeb_d;
  logic                 busy_q, busy_d;

  logic [ADDR_SH_W-1:0] shift_in;
  logic [1:0]           id_nxt;

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      addr_sh_q <= '0;
      tx_sh_q   <= '0;
      id_idx_q  <= '0;
      cmd_q     <= '0;
      addr_q    <= '0;
      rd_q      <= 1'b0;
      pend_q    <= 1'b0;
      do_q      <= 1'b0;
      oeb_q     <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      addr_sh_q <= addr_sh_d;
      tx_sh_q   <= tx_sh_d;
      id_idx_q  <= id_idx_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      rd_q      <= rd_d;
      pend_q    <= pend_d;
      do_q      <= do_d;
      oeb_q     <= oeb_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    addr_sh_d = addr_sh_q;
    tx_sh_d   = tx_sh_q;
    id_idx_d  = id_idx_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    do_d      = do_q;
    oeb_d     = oeb_q;
    rd_d      = 1'b0;
    pend_d    = rd_q;
    busy_d    = ~csb_s;
    shift_in  = {addr_sh_q, io0_s};
    id_nxt    = (id_idx_q == 2'd2) ? 2'd0 : id_idx_q + 2'd1;

    // Memory data arrives the cycle after the read strobe.
    if (pend_q) tx_sh_d = mem_rdata_i;

    // Deselect overrides any SCK activity in the same cycle.
    if (csb_s) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      tx_sh_d   = '0;
      id_idx_d  = '0;
      do_d      = 1'b0;
      oeb_d     = 1'b1;
      pend_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = CMD;
          bit_cnt_d = '0;
        end
        CMD: begin
          if (sck_rise) begin
            addr_sh_d = shift_in[ADDR_SH_W-2:0];
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            if (bit_cnt_q == BIT_CNT_W'(7)) begin
              bit_cnt_d = '0;
              cmd_d     = shift_in[7:0];
              if (shift_in[7:0] == CMD_READ) begin
                state_d = ADDR;
              end else if (shift_in[7:0] == CMD_RDID) begin
                state_d  = ID;
                id_idx_d = 2'd0;
                tx_sh_d  = id_byte(JEDEC_ID, 2'd0);
              end else begin
                state_d = IGNORE;
              end
            end
          end
        end
        ADDR: begin
          if (sck_rise) begin
            addr_sh_d = shift_in[ADDR_SH_W-2:0];
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            if (bit_cnt_q == BIT_CNT_W'(23)) begin
              bit_cnt_d = '0;
              addr_d    = shift_in[ADDR_W-1:0];
              rd_d      = 1'b1;
              state_d   = DATA;
            end
          end
        end
        DATA, ID: begin
          if (sck_fall) begin
            do_d    = tx_sh_q[7];
            tx_sh_d = {tx_sh_q[6:0], 1'b0};
            oeb_d   = 1'b0;
          end else if (sck_rise) begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            if (bit_cnt_q == BIT_CNT_W'(7)) begin
              bit_cnt_d = '0;
              if (state_q == DATA) begin
                addr_d = addr_q + ADDR_W'(1);
                rd_d   = 1'b1;
              end else begin
                id_idx_d = id_nxt;
                tx_sh_d  = id_byte(JEDEC_ID, id_nxt);
              end
            end
          end
        end
        IGNORE: begin
          oeb_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign flash_io1_do  = do_q;
  assign flash_io1_oeb = oeb_q;
  assign mem_rd_o      = rd_q;
  assign mem_addr_o    = addr_q;
  assign busy_o        = busy_q;
  assign cmd_o         = cmd_q;

endmodule

// File: tb/tb_spiflash_responder.sv
// Scoreboard bench for spiflash_responder: SPI mode-0 master, byte[a]=a[7:0] memory model.
module tb_spiflash_responder;

  localparam int unsigned ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              csb = 1'b1;
  logic              sck = 1'b0;
  logic              mosi = 1'b0;
  logic              miso_do;
  logic              miso_oeb;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata = 8'h00;
  logic              busy;
  logic [7:0]        cmd;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_addr_q[$];
  logic [7:0]  exp_byte_q[$];

  spiflash_responder #(.ADDR_W(ADDR_W), .JEDEC_ID(24'hEF4018)) dut (
    .wb_clk_i      (clk),
    .wb_rstn_i     (rst_n),
    .flash_csb     (csb),
    .flash_clk     (sck),
    .flash_io0_di  (mosi),
    .flash_io1_do  (miso_do),
    .flash_io1_oeb (miso_oeb),
    .mem_rd_o      (mem_rd),
    .mem_addr_o    (mem_addr),
    .mem_rdata_i   (mem_rdata),
    .busy_o        (busy),
    .cmd_o         (cmd)
  );

  always #5 clk = ~clk;

  // Synchronous byte memory: data valid the cycle after the strobe.
  always @(posedge clk) if (mem_rd) mem_rdata <= mem_addr[7:0];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Read-strobe scoreboard, sampled mid-cycle.
  logic rd_prev = 1'b0;
  always @(negedge clk) begin
    if (rd_prev) check_eq("rd_b2b", 32'(mem_rd), 32'd0);
    if (mem_rd) begin
      if (exp_addr_q.size() > 0) check_eq("rd_addr", 32'(mem_addr), exp_addr_q.pop_front());
      else                       check_eq("rd_spurious", 32'(mem_rd), 32'd0);
    end
    rd_prev = mem_rd;
  end

  // Shifts n bits MSB-first; MISO and OEB are captured on each SCK rise.
  task automatic spi_bits(input logic [31:0] tx, input int n,
                          output logic [31:0] rx, output logic [31:0] oebs);
    rx   = '0;
    oebs = '0;
    for (int i = n - 1; i >= 0; i--) begin
      mosi = tx[i];
      #50;
      sck  = 1'b1;
      rx   = {rx[30:0], miso_do};
      oebs = {oebs[30:0], miso_oeb};
      #50;
      sck  = 1'b0;
    end
  endtask

  task automatic csb_low();
    csb = 1'b0;
    #50;
    check_eq("busy_hi", 32'(busy), 32'd1);
  endtask

  task automatic csb_high();
    #50;
    csb = 1'b1;
    #200;
    check_eq("busy_lo", 32'(busy), 32'd0);
  endtask

  task automatic rx_bytes(input int nbytes);
    logic [31:0] rx, oebs;
    for (int k = 0; k < nbytes; k++) begin
      spi_bits(32'h0, 8, rx, oebs);
      if (exp_byte_q.size() > 0) check_eq("miso_byte", {24'h0, rx[7:0]}, 32'(exp_byte_q.pop_front()));
      check_eq("miso_oeb", {24'h0, oebs[7:0]}, 32'h0);
    end
  endtask

  task automatic read_open(input logic [23:0] a, input int nbytes);
    logic [31:0] rx, oebs;
    for (int k = 0; k <= nbytes; k++) exp_addr_q.push_back(32'((32'(a) + 32'(k)) & 32'h3FF));
    for (int k = 0; k < nbytes; k++) exp_byte_q.push_back(8'((32'(a) + 32'(k)) & 32'hFF));
    csb_low();
    spi_bits(32'h03, 8, rx, oebs);
    spi_bits({8'h0, a}, 24, rx, oebs);
    rx_bytes(nbytes);
  endtask

  task automatic read_tx(input logic [23:0] a, input int nbytes);
    read_open(a, nbytes);
    csb_high();
    check_eq("cmd_read", 32'(cmd), 32'h03);
    check_eq("rd_left", 32'(exp_addr_q.size()), 32'd0);
  endtask

  initial begin
    #1ms;
    n_err++;
    $display("FAIL timeout: got running expected finished");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    logic [31:0] rx, oebs;

    // Reset held with CSB low and SCK toggling
    csb = 1'b0;
    #23;
    for (int i = 0; i < 8; i++) begin
      sck = ~sck;
      mosi = ~mosi;
      #50;
      check_eq("rst_oeb", 32'(miso_oeb), 32'd1);
      check_eq("rst_do", 32'(miso_do), 32'd0);
      check_eq("rst_rd", 32'(mem_rd), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_cmd", 32'(cmd), 32'd0);
    end
    sck = 1'b0;
    csb = 1'b1;
    #50;
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    #200;

    // Plain read
    read_tx(24'h000010, 4);

    // Upper address bits dropped, address wrap
    read_tx(24'hFF03FE, 4);

    // JEDEC ID, repeating after three bytes, no memory reads
    exp_byte_q.push_back(8'hEF);
    exp_byte_q.push_back(8'h40);
    exp_byte_q.push_back(8'h18);
    exp_byte_q.push_back(8'hEF);
    csb_low();
    spi_bits(32'h9F, 8, rx, oebs);
    rx_bytes(4);
    csb_high();
    check_eq("cmd_rdid", 32'(cmd), 32'h9F);

    // Unknown commands are ignored
    csb_low();
    spi_bits(32'hFF, 8, rx, oebs);
    csb_high();
    check_eq("cmd_ff", 32'(cmd), 32'hFF);
    csb_low();
    spi_bits(32'hAB, 8, rx, oebs);
    spi_bits(32'h123456, 24, rx, oebs);
    check_eq("ign_oeb", {8'h0, oebs[23:0]}, 32'h00FF_FFFF);
    check_eq("ign_do", {8'h0, rx[23:0]}, 32'h0);
    csb_high();
    check_eq("cmd_ab", 32'(cmd), 32'hAB);

    // Abort three bits into the second data byte
    read_open(24'h000040, 1);
    spi_bits(32'h0, 3, rx, oebs);
    check_eq("abort_oeb_pre", {29'h0, oebs[2:0]}, 32'h0);
    check_eq("abort_bits", {29'h0, rx[2:0]}, 32'h2);
    csb = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_eq("abort_oeb", 32'(miso_oeb), 32'd1);
    check_eq("abort_do", 32'(miso_do), 32'd0);
    #200;
    check_eq("abort_rd_left", 32'(exp_addr_q.size()), 32'd0);
    read_tx(24'h000020, 1);

    // Async reset in the middle of a data byte
    read_open(24'h000100, 1);
    spi_bits(32'h0, 4, rx, oebs);
    sck = 1'b1;
    #20;
    check_eq("mid_oeb", 32'(miso_oeb), 32'd0);
    rst_n = 1'b0;
    #1;
    check_eq("arst_oeb", 32'(miso_oeb), 32'd1);
    check_eq("arst_do", 32'(miso_do), 32'd0);
    check_eq("arst_rd", 32'(mem_rd), 32'd0);
    check_eq("arst_addr", 32'(mem_addr), 32'd0);
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_cmd", 32'(cmd), 32'd0);
    #29;
    sck = 1'b0;
    csb = 1'b1;
    #50;
    rst_n = 1'b1;
    #200;
    check_eq("arst_rd_left", 32'(exp_addr_q.size()), 32'd0);
    read_tx(24'h000005, 1);

    check_eq("bytes_left", 32'(exp_byte_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
